// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for a single shared W-bit ALU.
// One op in flight at a time: accept in IDLE, compute in EXEC, hold result in RESP.

module yAlu #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] z,
    output logic         zero,
    output logic         err
);

    logic [W-1:0] b_eff;
    logic [W-1:0] sum;
    logic         slt;

    // op[2] selects subtract mode; SUB and SLT share the single adder
    always_comb begin
        b_eff = op[2] ? ~b : b;
        sum   = a + b_eff + {{(W-1){1'b0}}, op[2]};
        slt   = (a[W-1] != b[W-1]) ? a[W-1] : sum[W-1];
    end

    always_comb begin
        z   = '0;
        err = 1'b0;
        case (op)
            3'b000:  z = a & b;
            3'b001:  z = a | b;
            3'b010:  z = sum;
            3'b110:  z = sum;
            3'b111:  z = {{(W-1){1'b0}}, slt};
            default: begin
                z   = '0;
                err = 1'b1;
            end
        endcase
        zero = (z == '0);
    end

endmodule

// state | meaning
// IDLE  | arbitrate; the granted requester sees ready and its op is latched
// EXEC  | ALU evaluates latched operands; result captured on the edge
// RESP  | result held with rsp_valid until the consumer takes it
module alu_share_arb #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_z,
    output logic         rsp_zero,
    output logic         rsp_err,
    output logic         rsp_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [2:0]   op_q, op_d;
    logic         id_q, id_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [W-1:0] rsp_z_q, rsp_z_d;
    logic         rsp_zero_q, rsp_zero_d;
    logic         rsp_err_q, rsp_err_d;
    logic         rsp_id_q, rsp_id_d;

    logic         grant0;
    logic         grant1;
    logic [W-1:0] alu_z;
    logic         alu_zero;
    logic         alu_err;

    yAlu #(.W(W)) u_alu (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .z    (alu_z),
        .zero (alu_zero),
        .err  (alu_err)
    );

    // Ties go to whichever requester was not served last
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant_q);
        grant1     = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = (state_q == S_IDLE) && grant0;
        req1_ready = (state_q == S_IDLE) && grant1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_z_d      = rsp_z_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        rsp_id_d     = rsp_id_q;

        case (state_q)
            S_IDLE: begin
                if (req0_ready) begin
                    a_d          = req0_a;
                    b_d          = req0_b;
                    op_d         = req0_op;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = S_EXEC;
                end else if (req1_ready) begin
                    a_d          = req1_a;
                    b_d          = req1_b;
                    op_d         = req1_op;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_z_d     = alu_z;
                rsp_zero_d  = alu_zero;
                rsp_err_d   = alu_err;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_z_q      <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_z_q      <= rsp_z_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: cycle model of grant/phase plus a result scoreboard.

module tb_alu_share_arb;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         req0_valid, req0_ready;
    logic [W-1:0] req0_a, req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid, req1_ready;
    logic [W-1:0] req1_a, req1_b;
    logic [2:0]   req1_op;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_z;
    logic         rsp_zero, rsp_err, rsp_id;

    alu_share_arb #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_z      (rsp_z),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .rsp_id     (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W+2:0] sb_q[$];    // {id, err, zero, z}
    logic         gq[$];
    logic [W-1:0] zq[$];
    int           ph = 0;     // 0 idle, 1 exec, 2 resp
    logic         last_g = 1'b1;
    logic         acc0, acc1;
    logic [W+2:0] last_rsp = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+2:0] model(input logic id, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [2:0] op);
        logic [W-1:0] z;
        logic         e;
        e = 1'b0;
        case (op)
            3'b000:  z = a & b;
            3'b001:  z = a | b;
            3'b010:  z = a + b;
            3'b110:  z = a - b;
            3'b111:  z = ($signed(a) < $signed(b)) ? 1 : 0;
            default: begin z = '0; e = 1'b1; end
        endcase
        return {id, e, (z == '0), z};
    endfunction

    task automatic tick();
        logic         e0, e1;
        logic [W+2:0] exp;
        @(negedge clk);
        e0 = (ph == 0) && req0_valid && (!req1_valid || last_g);
        e1 = (ph == 0) && req1_valid && (!req0_valid || !last_g);
        chk("req0_ready", W'(req0_ready), W'(e0));
        chk("req1_ready", W'(req1_ready), W'(e1));
        chk("rsp_valid", W'(rsp_valid), W'(ph == 2));
        acc0 = e0;
        acc1 = e1;
        case (ph)
            0: begin
                if (e0) begin
                    sb_q.push_back(model(1'b0, req0_a, req0_b, req0_op));
                    gq.push_back(1'b0);
                    last_g = 1'b0;
                    ph = 1;
                end else if (e1) begin
                    sb_q.push_back(model(1'b1, req1_a, req1_b, req1_op));
                    gq.push_back(1'b1);
                    last_g = 1'b1;
                    ph = 1;
                end
            end
            1: ph = 2;
            default: begin
                chk("sb_nonempty", W'(sb_q.size() != 0), W'(1));
                if (sb_q.size() != 0) begin
                    exp = sb_q[0];
                    chk("rsp_z", rsp_z, exp[W-1:0]);
                    chk("rsp_zero", W'(rsp_zero), W'(exp[W]));
                    chk("rsp_err", W'(rsp_err), W'(exp[W+1]));
                    chk("rsp_id", W'(rsp_id), W'(exp[W+2]));
                    if (rsp_ready) begin
                        last_rsp = {rsp_id, rsp_err, rsp_zero, rsp_z};
                        zq.push_back(rsp_z);
                        void'(sb_q.pop_front());
                        ph = 0;
                    end
                end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (ph != 0 || sb_q.size() != 0); i++) tick();
        chk("drain_done", W'(ph == 0 && sb_q.size() == 0), W'(1));
    endtask

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input bit wait_rsp);
        logic got;
        got = 1'b0;
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = id ? acc1 : acc0;
        end
        chk("accept_seen", W'(got), W'(1));
        if (id == 1'b0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        if (wait_rsp) drain();
    endtask

    task automatic chk_rsp(input string tag, input logic [W-1:0] z, input logic zero,
                           input logic err, input logic id);
        chk({tag, "_z"}, last_rsp[W-1:0], z);
        chk({tag, "_zero"}, W'(last_rsp[W]), W'(zero));
        chk({tag, "_err"}, W'(last_rsp[W+1]), W'(err));
        chk({tag, "_id"}, W'(last_rsp[W+2]), W'(id));
    endtask

    task automatic wait_resp_phase();
        for (int i = 0; i < 10 && ph != 2; i++) tick();
        chk("reached_resp", W'(ph == 2), W'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, W'(rsp_valid), W'(0));
        chk({tag, "_rsp_z"}, rsp_z, '0);
        chk({tag, "_rsp_zero"}, W'(rsp_zero), W'(0));
        chk({tag, "_rsp_err"}, W'(rsp_err), W'(0));
        chk({tag, "_rsp_id"}, W'(rsp_id), W'(0));
    endtask

    task automatic model_reset();
        sb_q.delete();
        ph = 0;
        last_g = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b1;
        #12;
        check_reset_outputs("reset");
        chk("reset_req0_ready", W'(req0_ready), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Single op and signed arithmetic corners
        issue(1'b0, 32'd7, 32'd5, 3'b010, 1'b1);
        chk_rsp("add", 32'd12, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 32'hFFFF_FFFD, 32'd2, 3'b111, 1'b1);
        chk_rsp("slt_neg", 32'd1, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 32'd2, 32'hFFFF_FFFD, 3'b111, 1'b1);
        chk_rsp("slt_pos", 32'd0, 1'b1, 1'b0, 1'b1);
        issue(1'b1, 32'h1234, 32'h1234, 3'b110, 1'b1);
        chk_rsp("sub_eq", 32'd0, 1'b1, 1'b0, 1'b1);
        issue(1'b0, 32'hFFFF_FFFF, 32'd2, 3'b010, 1'b1);
        chk_rsp("add_wrap", 32'd1, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 32'h8000_0000, 32'd1, 3'b111, 1'b1);
        chk_rsp("slt_min", 32'd1, 1'b0, 1'b0, 1'b0);

        // Illegal op then a legal one
        issue(1'b0, 32'hABCD, 32'h1, 3'b011, 1'b1);
        chk_rsp("illegal", 32'd0, 1'b1, 1'b1, 1'b0);
        issue(1'b0, 32'd1, 32'd2, 3'b001, 1'b1);
        chk_rsp("after_illegal", 32'd3, 1'b0, 1'b0, 1'b0);

        // Backpressure with the other requester waiting
        rsp_ready = 1'b0;
        issue(1'b0, 32'hF0F0, 32'hFF00, 3'b000, 1'b0);
        wait_resp_phase();
        req1_a = 32'd10; req1_b = 32'd3; req1_op = 3'b110; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rsp_ready = 1'b1;
        tick();
        chk_rsp("stall", 32'hF000, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 32'd10, 32'd3, 3'b110, 1'b1);
        chk_rsp("after_stall", 32'd7, 1'b0, 1'b0, 1'b1);

        // Reset while in EXEC
        issue(1'b1, 32'd4, 32'd4, 3'b010, 1'b0);
        chk("in_exec", W'(ph), W'(1));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_exec");
        model_reset();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while holding a response
        rsp_ready = 1'b0;
        issue(1'b1, 32'd9, 32'd9, 3'b001, 1'b0);
        wait_resp_phase();
        chk("resp_valid_before_rst", W'(rsp_valid), W'(1));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_resp");
        model_reset();
        rsp_ready = 1'b1;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) tick();

        // Round-robin with both requesters continuously valid
        gq.delete();
        zq.delete();
        req0_a = 32'hF0F0; req0_b = 32'hFF00; req0_op = 3'b000;
        req1_a = 32'hF0F0; req1_b = 32'hFF00; req1_op = 3'b001;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 40 && gq.size() < 6; i++) tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        drain();
        chk("rr_grants", W'(gq.size()), W'(6));
        chk("rr_rsps", W'(zq.size()), W'(6));
        for (int i = 0; i < 6 && i < gq.size() && i < zq.size(); i++) begin
            chk("rr_grant_id", W'(gq[i]), W'(i % 2));
            chk("rr_z", zq[i], (i % 2 == 0) ? 32'hF000 : 32'hFFF0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
